// File: rtl/dpg_pkg.sv
// Shared definitions for the discrete pulse generator: config address codes,
// CTRL bit positions and the per-channel state encoding.
// DPG_ONESHOT_EN adds the one-shot CTRL bit definition.
package dpg_pkg;

    // cfg_addr codes
    localparam logic [1:0] CFG_PERIOD = 2'd0;
    localparam logic [1:0] CFG_START  = 2'd1;
    localparam logic [1:0] CFG_STOP   = 2'd2;
    localparam logic [1:0] CFG_CTRL   = 2'd3;

    // CTRL bit indices
    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 2;
`ifdef DPG_ONESHOT_EN
    localparam int CTRL_ONESHOT = 1;
`endif

    // Channel state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_t;

endpackage

// File: rtl/dpg_chan.sv
// One pulse channel: shadow/active window registers, phase counter, state
// machine and registered outputs. With DPG_ONESHOT_EN defined, CTRL[1] stops
// the channel after one period and issues a done strobe.
module dpg_chan
    import dpg_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk_in,
    input  logic          rst_board,
    input  logic          ena,
    input  logic          sync_clr,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    output logic          pulse_out,
    output logic          pulse_rise,
    output logic          done
);

    localparam logic [CW-1:0] ONE = CW'(1);

    chan_state_t   state, state_n;
    logic [CW-1:0] sh_period, sh_start, sh_stop;
    logic [CW-1:0] act_period, act_start, act_stop;
    logic [CW-1:0] cnt, cnt_n;
    logic          en_q, inv_q;
    logic          win_q, win_n;
    logic          pulse_q, pulse_n, rise_q, rise_n;
    logic          load;
`ifdef DPG_ONESHOT_EN
    logic          oneshot_q;
    logic          go_done;
    logic          done_q;
`endif

    function automatic logic in_window(input logic [CW-1:0] c,
                                       input logic [CW-1:0] s,
                                       input logic [CW-1:0] e);
        return (c >= s) && (c < e);
    endfunction

    // Config writes land in shadow registers and the CTRL bits
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values; blocking here would create races.
    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) begin
            sh_period <= '0;
            sh_start  <= '0;
            sh_stop   <= '0;
            en_q      <= 1'b0;
            inv_q     <= 1'b0;
`ifdef DPG_ONESHOT_EN
            oneshot_q <= 1'b0;
`endif
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_PERIOD: sh_period <= cfg_wdata;
                CFG_START:  sh_start  <= cfg_wdata;
                CFG_STOP:   sh_stop   <= cfg_wdata;
                default: begin
                    en_q  <= cfg_wdata[CTRL_EN];
                    inv_q <= cfg_wdata[CTRL_INV];
`ifdef DPG_ONESHOT_EN
                    oneshot_q <= cfg_wdata[CTRL_ONESHOT];
`endif
                end
            endcase
        end
    end

    // Next state, counter and window evaluation for this cycle
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        win_n   = win_q;
        pulse_n = pulse_q;
        rise_n  = 1'b0;
`ifdef DPG_ONESHOT_EN
        go_done = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (ena) begin
                    win_n = 1'b0;
                    if (en_q) begin
                        // The start cycle is count 0 of the first period, judged
                        // against the values being loaded now.
                        state_n = ST_RUN;
                        load    = 1'b1;
                        win_n   = in_window('0, sh_start, sh_stop);
                        cnt_n   = ((sh_period - ONE) == '0) ? '0 : ONE;
                    end
                    pulse_n = win_n ^ inv_q;
                    rise_n  = win_n & ~win_q;
                end
            end
            ST_RUN: begin
                if (!en_q && (ena || sync_clr)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    win_n   = 1'b0;
                    pulse_n = inv_q;
                end else if (sync_clr) begin
                    // Restart wins over a hold and over a same-cycle wrap
                    cnt_n   = '0;
                    load    = 1'b1;
                    win_n   = 1'b0;
                    pulse_n = inv_q;
                end else if (ena) begin
                    win_n   = in_window(cnt, act_start, act_stop);
                    pulse_n = win_n ^ inv_q;
                    rise_n  = win_n & ~win_q;
                    if (cnt == (act_period - ONE)) begin
                        cnt_n = '0;
                        load  = 1'b1;
`ifdef DPG_ONESHOT_EN
                        if (oneshot_q) begin
                            state_n = ST_DONE;
                            go_done = 1'b1;
                            win_n   = 1'b0;
                            pulse_n = inv_q;
                            rise_n  = 1'b0;
                        end
`endif
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            ST_DONE: begin
                if (ena) begin
                    win_n   = 1'b0;
                    pulse_n = inv_q;
                    if (!en_q) state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) state <= ST_IDLE;
        else            state <= state_n;
    end

    // Counter, active window registers and output registers
    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) begin
            cnt        <= '0;
            act_period <= '0;
            act_start  <= '0;
            act_stop   <= '0;
            win_q      <= 1'b0;
            pulse_q    <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            win_q   <= win_n;
            pulse_q <= pulse_n;
            rise_q  <= rise_n;
            if (load) begin
                act_period <= sh_period;
                act_start  <= sh_start;
                act_stop   <= sh_stop;
            end
        end
    end

    assign pulse_out  = pulse_q;
    assign pulse_rise = rise_q;

`ifdef DPG_ONESHOT_EN
    // One-cycle strobe on entry to DONE
    always_ff @(posedge clk_in or negedge rst_board) begin
        if (!rst_board) done_q <= 1'b0;
        else            done_q <= go_done;
    end
    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule

// File: rtl/disc_pulse_gen.sv
// Multi-channel programmable discrete-pulse generator. Decodes the channel
// select of the config port and replicates dpg_chan NCH times.
// DPG_ONESHOT_EN enables the one-shot mode and the done strobes.
module disc_pulse_gen
    import dpg_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           rst_board,
    input  logic           ena,
    input  logic           sync_clr,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_addr,
    input  logic [CW-1:0]  cfg_wdata,
    output logic [NCH-1:0] pulse_out,
    output logic [NCH-1:0] pulse_rise,
    output logic [NCH-1:0] done
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Channel selects outside 0..NCH-1 match no channel and are dropped
        logic we_ch;
        assign we_ch = cfg_we && (cfg_ch == CHW'(i));

        dpg_chan #(.CW(CW)) u_chan (
            .clk_in     (clk_in),
            .rst_board  (rst_board),
            .ena        (ena),
            .sync_clr   (sync_clr),
            .cfg_we     (we_ch),
            .cfg_addr   (cfg_addr),
            .cfg_wdata  (cfg_wdata),
            .pulse_out  (pulse_out[i]),
            .pulse_rise (pulse_rise[i]),
            .done       (done[i])
        );
    end

endmodule

// File: tb/tb_disc_pulse_gen.sv
// Directed bench for disc_pulse_gen (NCH=2, CW=10). Expected counts and
// cycle positions are hand-derived; the one-shot expectations follow
// DPG_ONESHOT_EN.
module tb_disc_pulse_gen;

`ifdef DPG_ONESHOT_EN
    localparam bit OS = 1'b1;
`else
    localparam bit OS = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_board;
    logic       ena, sync_clr, cfg_we;
    logic [0:0] cfg_ch;
    logic [1:0] cfg_addr;
    logic [9:0] cfg_wdata;
    logic [1:0] pulse_out, pulse_rise, done;

    int n_cmp = 0;
    int n_bad = 0;
    int hi0, hi1, lo1, rise0, rise1, done0;

    disc_pulse_gen #(.NCH(2), .CW(10)) dut (
        .clk_in     (clk_in),
        .rst_board  (rst_board),
        .ena        (ena),
        .sync_clr   (sync_clr),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .pulse_out  (pulse_out),
        .pulse_rise (pulse_rise),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        hi0 = 0; hi1 = 0; lo1 = 0; rise0 = 0; rise1 = 0; done0 = 0;
    endtask

    // One clock; sample 1 time unit after the edge and accumulate
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (pulse_out[0])  hi0++;
        if (pulse_out[1])  hi1++;
        if (!pulse_out[1]) lo1++;
        if (pulse_rise[0]) rise0++;
        if (pulse_rise[1]) rise1++;
        if (done[0])       done0++;
    endtask

    task automatic watch(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic ch, input logic [1:0] a, input logic [9:0] d);
        cfg_ch = ch; cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_board = 1'b0; ena = 1'b0; sync_clr = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        #12;
        check("rst_pulse_out",  int'(pulse_out),  0);
        check("rst_pulse_rise", int'(pulse_rise), 0);
        check("rst_done",       int'(done),       0);
        #10 rst_board = 1'b1;
        ena = 1'b1;

        // T2 setup for ch1, then T1 for ch0 (ch0 EN lands last)
        wr(1'b1, 2'd0, 10'd0);
        wr(1'b1, 2'd1, 10'd400);
        wr(1'b1, 2'd2, 10'd500);
        wr(1'b1, 2'd3, 10'd5);
        wr(1'b0, 2'd0, 10'd0);
        wr(1'b0, 2'd1, 10'd100);
        wr(1'b0, 2'd2, 10'd120);
        wr(1'b0, 2'd3, 10'd1);
        clear_counts();
        watch(100);
        check("t1_quiet_before_start", hi0, 0);
        tick();
        check("t1_first_pulse", int'(pulse_out[0]), 1);
        check("t1_first_rise",  int'(pulse_rise[0]), 1);
        clear_counts();
        watch(1024);
        check("t1_high_per_period", hi0, 20);
        check("t1_rises_per_period", rise0, 1);
        check("t1_second_rise_at_1125", int'(pulse_rise[0]), 1);
        check("t2_low_per_period", lo1, 100);
        check("t2_active_edges", rise1, 1);

        // T3: move the window while ch0 is mid-pulse
        clear_counts();
        wr(1'b0, 2'd1, 10'd200);
        wr(1'b0, 2'd2, 10'd220);
        watch(18);
        check("t3_current_pulse_kept", hi0, 19);
        check("t3_pulse_ended", int'(pulse_out[0]), 0);
        clear_counts();
        watch(1103);
        check("t3_no_pulse_at_old_start", hi0, 0);
        tick();
        check("t3_rise_at_new_start", int'(pulse_rise[0]), 1);
        clear_counts();
        watch(20);
        check("t3_new_width", hi0, 19);

        // T4: stop beyond the period end
        wr(1'b0, 2'd3, 10'd0);
        wr(1'b0, 2'd0, 10'd10);
        wr(1'b0, 2'd1, 10'd8);
        wr(1'b0, 2'd2, 10'd12);
        wr(1'b0, 2'd3, 10'd1);
        clear_counts();
        watch(8);
        check("t4_quiet_before_8", hi0, 0);
        tick();
        check("t4_rise_at_cnt8", int'(pulse_rise[0]), 1);
        tick();
        check("t4_high_at_cnt9", int'(pulse_out[0]), 1);
        tick();
        check("t4_low_after_wrap", int'(pulse_out[0]), 0);
        watch(20);
        clear_counts();
        watch(100);
        check("t4_high_count", hi0, 20);
        check("t4_rise_count", rise0, 10);

        // T4b: empty window
        wr(1'b0, 2'd1, 10'd5);
        wr(1'b0, 2'd2, 10'd5);
        watch(30);
        clear_counts();
        watch(100);
        check("t4b_never_active", hi0, 0);
        check("t4b_no_rise", rise0, 0);

        // T5: one-shot (ignored without DPG_ONESHOT_EN)
        wr(1'b0, 2'd3, 10'd0);
        wr(1'b0, 2'd0, 10'd50);
        wr(1'b0, 2'd1, 10'd10);
        wr(1'b0, 2'd2, 10'd20);
        wr(1'b0, 2'd3, 10'd3);
        clear_counts();
        watch(49);
        check("t5_first_width", hi0, 10);
        check("t5_first_rises", rise0, 1);
        check("t5_done_before_wrap", done0, 0);
        tick();
        check("t5_done_strobe", int'(done[0]), OS ? 1 : 0);
        clear_counts();
        watch(150);
        check("t5_later_high", hi0, OS ? 0 : 30);
        check("t5_done_once", done0, 0);
        wr(1'b0, 2'd3, 10'd0);
        wr(1'b0, 2'd3, 10'd3);
        clear_counts();
        watch(49);
        check("t5_rearm_width", hi0, 10);

        // T6: sync_clr phase-aligns both channels
        wr(1'b0, 2'd3, 10'd0);
        wr(1'b0, 2'd0, 10'd100);
        wr(1'b0, 2'd1, 10'd20);
        wr(1'b0, 2'd2, 10'd30);
        wr(1'b0, 2'd3, 10'd1);
        wr(1'b1, 2'd0, 10'd100);
        wr(1'b1, 2'd1, 10'd20);
        wr(1'b1, 2'd2, 10'd30);
        wr(1'b1, 2'd3, 10'd1);
        watch(3);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        check("t6_sync_inactive", int'(pulse_out), 0);
        clear_counts();
        watch(20);
        check("t6_sync_quiet_ch0", hi0, 0);
        check("t6_sync_quiet_ch1", hi1, 0);
        tick();
        check("t6_aligned_pulse", int'(pulse_out), 3);
        check("t6_aligned_rise",  int'(pulse_rise), 3);

        // T6: ena low for 30 clk mid-pulse stretches it
        clear_counts();
        watch(4);
        ena = 1'b0;
        watch(30);
        ena = 1'b1;
        watch(20);
        check("t6_stretch_ch0", hi0, 39);
        check("t6_stretch_ch1", hi1, 39);
        check("t6_no_rise_in_hold", rise0, 0);

        // T6: asynchronous reset mid-pulse
        watch(76);
        check("t6_pre_reset_pulse", int'(pulse_out), 3);
        check("t6_pre_reset_rise",  int'(pulse_rise), 3);
        rst_board = 1'b0;
        #2;
        check("t6_async_rst_pulse", int'(pulse_out), 0);
        check("t6_async_rst_rise",  int'(pulse_rise), 0);
        check("t6_async_rst_done",  int'(done), 0);
        #3 rst_board = 1'b1;
        clear_counts();
        watch(50);
        check("t6_idle_after_reset", hi0 + hi1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
